// File: rtl/ccc_reconfig_pkg.sv
// Shared types and defaults for the CCC dynamic-configuration APB initiator.
package ccc_reconfig_pkg;

    localparam int              CCC_ADDR_W      = 6;
    localparam int              CCC_DATA_W      = 8;
    localparam logic [5:0]      CCC_COMMIT_ADDR = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_PLL_RST,
        ST_LOCK_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/ccc_lock_monitor.sv
// PLL lock qualifier: 2-flop synchronizer, consecutive-high counter and relock timeout.
// With CCC_RECONFIG_PLL_RST_EN the synchronizer history is also cleared by start.
module ccc_lock_monitor #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock,
    input  logic start,
    input  logic active,
    output logic lock_ok,
    output logic lock_timeout
);
    localparam int SCW = $clog2(LOCK_STABLE) + 1;
    localparam int TCW = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [SCW-1:0] STABLE_MAX = SCW'(LOCK_STABLE);
    localparam logic [TCW-1:0] TMO_MAX    = TCW'(LOCK_TIMEOUT);

    logic [1:0]     sync;
    logic [SCW-1:0] stable_cnt;
    logic [TCW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
`ifdef CCC_RECONFIG_PLL_RST_EN
        end else if (start) begin
            sync <= '0;
`endif
        end else begin
            sync <= {sync[0], lock};
        end
    end

    // Both counters saturate at their thresholds; start re-arms them for a new relock.
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            stable_cnt <= '0;
            tmo_cnt    <= '0;
        end else if (active) begin
            if (!sync[1])
                stable_cnt <= '0;
            else if (stable_cnt != STABLE_MAX)
                stable_cnt <= stable_cnt + 1'b1;
            if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign lock_ok      = active && (stable_cnt >= STABLE_MAX);
    assign lock_timeout = active && (tmo_cnt >= TMO_MAX);

endmodule

// File: rtl/ccc_apb_reconfig_master.sv
// APB3 initiator for the CCC dynamic-configuration port; a commit write waits for PLL relock.
// Define CCC_RECONFIG_PLL_RST_EN to pulse PLL_ARST_N low before the relock wait.
module ccc_apb_reconfig_master
    import ccc_reconfig_pkg::*;
#(
    parameter int                ADDR_W         = CCC_ADDR_W,
    parameter int                DATA_W         = CCC_DATA_W,
    parameter logic [ADDR_W-1:0] COMMIT_ADDR    = CCC_COMMIT_ADDR,
    parameter int                BUSY_TIMEOUT   = 64,
    parameter int                LOCK_TIMEOUT   = 4096,
    parameter int                LOCK_STABLE    = 4,
    parameter int                PLL_RST_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              BUSY,
    input  logic              LOCK,
    output logic              PLL_ARST_N,
    output logic              relocking
);
    localparam int BCW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [BCW-1:0] BUSY_MAX  = BCW'(BUSY_TIMEOUT);
    localparam logic [BCW-1:0] BUSY_LAST = BCW'(BUSY_TIMEOUT - 1);

    state_t         state;
    state_t         state_next;
    logic [BCW-1:0] busy_cnt;
    logic           commit_hit;
    logic           lock_start;
    logic           lock_active;
    logic           lock_ok;
    logic           lock_timeout;

    assign commit_hit = PWRITE && (PADDR == COMMIT_ADDR);

`ifdef CCC_RECONFIG_PLL_RST_EN
    localparam int PCW = $clog2(PLL_RST_CYCLES) + 1;
    localparam logic [PCW-1:0] PLL_LAST = PCW'(PLL_RST_CYCLES - 1);
    localparam state_t COMMIT_NEXT = ST_PLL_RST;

    logic [PCW-1:0] pll_cnt;
    logic           pll_arst_n;

    // PLL reset is registered so the CCC never sees a decode glitch on its async reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            pll_cnt    <= '0;
            pll_arst_n <= 1'b1;
        end else begin
            pll_cnt    <= (state == ST_PLL_RST && pll_cnt != PLL_LAST) ? pll_cnt + 1'b1 : '0;
            pll_arst_n <= (state_next != ST_PLL_RST);
        end
    end

    assign PLL_ARST_N = pll_arst_n;
`else
    localparam state_t COMMIT_NEXT = ST_LOCK_WAIT;

    assign PLL_ARST_N = 1'b1;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESET_N)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        rsp_valid  = 1'b0;
        relocking  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = ST_SETUP;
            end
            ST_SETUP: begin
                PSEL       = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (!BUSY)
                    state_next = commit_hit ? COMMIT_NEXT : ST_RESP;
                else if (busy_cnt == BUSY_LAST)
                    state_next = ST_RESP;
            end
`ifdef CCC_RECONFIG_PLL_RST_EN
            ST_PLL_RST: begin
                relocking = 1'b1;
                if (pll_cnt == PLL_LAST)
                    state_next = ST_LOCK_WAIT;
            end
`endif
            ST_LOCK_WAIT: begin
                relocking = 1'b1;
                if (lock_ok || lock_timeout)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command capture, BUSY wait accounting and response formation.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PADDR     <= cmd_addr;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        busy_cnt  <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (!BUSY) begin
                        if (!PWRITE)
                            rsp_rdata <= PRDATA;
                    end else begin
                        if (busy_cnt != BUSY_MAX)
                            busy_cnt <= busy_cnt + 1'b1;
                        if (busy_cnt == BUSY_LAST)
                            rsp_err <= 1'b1;
                    end
                end
                ST_LOCK_WAIT: begin
                    if (lock_timeout && !lock_ok)
                        rsp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign lock_active = (state == ST_LOCK_WAIT);
    assign lock_start  = (state_next == ST_LOCK_WAIT) && (state != ST_LOCK_WAIT);

    ccc_lock_monitor #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE)
    ) u_lock_monitor (
        .clk          (PCLK),
        .rst_n        (PRESET_N),
        .lock         (LOCK),
        .start        (lock_start),
        .active       (lock_active),
        .lock_ok      (lock_ok),
        .lock_timeout (lock_timeout)
    );

endmodule

// File: tb/tb_ccc_apb_reconfig_master.sv
// Self-checking bench for ccc_apb_reconfig_master (honours CCC_RECONFIG_PLL_RST_EN when defined).
module tb_ccc_apb_reconfig_master;

    localparam int         ADDR_W         = 6;
    localparam int         DATA_W         = 8;
    localparam logic [5:0] COMMIT_ADDR    = 6'h3F;
    localparam int         BUSY_TIMEOUT   = 64;
    localparam int         LOCK_TIMEOUT   = 4096;
    localparam int         LOCK_STABLE    = 4;
    localparam int         PLL_RST_CYCLES = 16;
`ifdef CCC_RECONFIG_PLL_RST_EN
    localparam int         EXP_ARST_LOW   = PLL_RST_CYCLES;
`else
    localparam int         EXP_ARST_LOW   = 0;
`endif

    logic              PCLK = 1'b0;
    logic              PRESET_N;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              BUSY;
    logic              LOCK;
    logic              PLL_ARST_N;
    logic              relocking;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 PCLK = ~PCLK;

    ccc_apb_reconfig_master dut (
        .PCLK       (PCLK),
        .PRESET_N   (PRESET_N),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .BUSY       (BUSY),
        .LOCK       (LOCK),
        .PLL_ARST_N (PLL_ARST_N),
        .relocking  (relocking)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One APB command; the slave holds BUSY for k ACCESS cycles then returns rd.
    task automatic run_cmd(input bit wr, input logic [5:0] a, input logic [7:0] wd,
                           input int k, input logic [7:0] rd);
        int   cyc, acc, first_acc, hold_bad, exp_lat;
        bit   got, exp_err;
        logic [7:0] exp_rd;
        exp_err = (k >= BUSY_TIMEOUT);
        exp_lat = exp_err ? BUSY_TIMEOUT + 2 : k + 3;
        exp_rd  = (wr || exp_err) ? 8'h00 : rd;
        @(negedge PCLK);
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        check("rsp_valid_idle", 32'(rsp_valid), 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 6'($urandom_range(0, 63));
        cmd_wdata = 8'($urandom_range(0, 255));
        check("setup_phase", 32'({PSEL, PENABLE, cmd_ready}), 32'b100);
        check("setup_addr", 32'({PWRITE, PADDR, PWDATA}), 32'({wr, a, wd}));
        cyc = 1; acc = 0; first_acc = 0; hold_bad = 0; got = 0;
        while (!got && cyc < 200) begin
            if (PSEL && PENABLE) begin
                if (first_acc == 0) first_acc = cyc;
                BUSY   = (acc < k);
                PRDATA = (acc < k) ? 8'($urandom_range(0, 255)) : rd;
                acc++;
            end else begin
                BUSY = 1'b0;
            end
            @(negedge PCLK);
            cyc++;
            if (rsp_valid) got = 1;
            else if (PSEL && {PWRITE, PADDR, PWDATA} !== {wr, a, wd}) hold_bad++;
        end
        BUSY = 1'b0;
        check("rsp_seen", 32'(got), 1);
        check("rsp_latency", 32'(cyc), 32'(exp_lat));
        check("first_access", 32'(first_acc), 2);
        check("access_cycles", 32'(acc), exp_err ? 32'(BUSY_TIMEOUT) : 32'(k + 1));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (!exp_err) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("apb_idle_at_rsp", 32'({PSEL, PENABLE, relocking}), 0);
        check("apb_hold", 32'(hold_bad), 0);
    endtask

    function automatic logic lock_at(input int mode, input int c);
        case (mode)
            0:       return (c >= 100);
            1:       return (c >= 30 && c != 33);
            default: return 1'b0;
        endcase
    endfunction

    // Commit write; mode 0 = LOCK rises late, 1 = glitch then stable, 2 = never locks.
    task automatic run_commit(input int mode);
        int cyc, run, reloc_bad, arst_low;
        bit got;
        LOCK = 1'b0;
        @(negedge PCLK);
        check("commit_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = COMMIT_ADDR;
        cmd_wdata = 8'($urandom_range(0, 255));
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cyc = 1; run = 0; reloc_bad = 0; arst_low = 0; got = 0;
        while (!got && cyc < LOCK_TIMEOUT + 300) begin
            BUSY = 1'b0;
            LOCK = lock_at(mode, cyc);
            run  = LOCK ? run + 1 : 0;
            @(negedge PCLK);
            cyc++;
            if (!PLL_ARST_N) arst_low++;
            if (rsp_valid) got = 1;
            else if (cyc >= 3 && !relocking) reloc_bad++;
        end
        check("commit_rsp_seen", 32'(got), 1);
        check("commit_relocking_held", 32'(reloc_bad), 0);
        check("commit_relocking_end", 32'(relocking), 0);
        check("commit_arst_low", 32'(arst_low), 32'(EXP_ARST_LOW));
        check("commit_rdata", 32'(rsp_rdata), 0);
        if (mode == 2) begin
            check("commit_err_timeout", 32'(rsp_err), 1);
            check("commit_tmo_window",
                  32'(cyc >= LOCK_TIMEOUT && cyc <= LOCK_TIMEOUT + 3 + EXP_ARST_LOW + 4), 1);
        end else begin
            check("commit_err_ok", 32'(rsp_err), 0);
            check("commit_stable_run",
                  32'(run >= LOCK_STABLE + 2 && run <= LOCK_STABLE + 4), 1);
            if (mode == 0)
                check("commit_lock_latency", 32'(cyc <= 100 + 2 + LOCK_STABLE + 3), 1);
        end
        LOCK = 1'b0;
    endtask

    task automatic run_reset_abort();
        bit seen;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 6'h2A;
        cmd_wdata = 8'h00;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        BUSY      = 1'b1;
        repeat (3) @(negedge PCLK);
        check("abort_in_access", 32'({PSEL, PENABLE}), 32'b11);
        PRESET_N = 1'b0;
        @(negedge PCLK);
        check("abort_apb_idle", 32'({PSEL, PENABLE}), 0);
        check("abort_no_rsp", 32'(rsp_valid), 0);
        check("abort_ready", 32'(cmd_ready), 1);
        PRESET_N = 1'b1;
        BUSY     = 1'b0;
        seen     = 0;
        repeat (6) begin
            @(negedge PCLK);
            if (rsp_valid) seen = 1;
        end
        check("abort_no_late_rsp", 32'(seen), 0);
        check("abort_ready_after", 32'(cmd_ready), 1);
    endtask

    initial begin
        bit         wr;
        logic [5:0] a;
        logic [7:0] wd, rd;
        int         k;
        PRESET_N  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        BUSY      = 1'b0;
        LOCK      = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 0);
        check("rst_apb_ctrl", 32'({PSEL, PENABLE, PWRITE}), 0);
        check("rst_paddr", 32'(PADDR), 0);
        check("rst_pwdata", 32'(PWDATA), 0);
        check("rst_pll", 32'({PLL_ARST_N, relocking}), 32'b10);
        PRESET_N = 1'b1;

        run_cmd(1'b0, 6'h05, 8'h00, 0, 8'hA7);
        run_cmd(1'b1, 6'h10, 8'h3C, 5, 8'h00);
        run_cmd(1'b0, 6'h21, 8'h00, 100, 8'h55);
        run_cmd(1'b1, 6'h00, 8'hFF, 0, 8'h00);

        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 62));
            wd = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            k  = ($urandom_range(0, 11) == 0) ? BUSY_TIMEOUT + int'($urandom_range(0, 5))
                                              : int'($urandom_range(0, 6));
            run_cmd(wr, a, wd, k, rd);
        end

        run_commit(0);
        run_commit(1);
        run_commit(2);

        run_reset_abort();
        run_cmd(1'b0, 6'h3E, 8'h00, 2, 8'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ccc_apb_reconfig_master.md
Name: ccc_apb_reconfig_master

Overview:
- APB3-style initiator that drives the CCC dynamic-configuration port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/BUSY) at runtime, replacing the tied-off configuration interface of the clock-conditioning wrapper.
- Accepts single register read/write commands from a local controller over a valid/ready handshake.
- A write to the commit address triggers a PLL relock wait, with a timeout.
- Sits between the system controller and the CCC instance, in the PCLK domain.

Parameters:
ADDR_W, 6, CCC config address width
DATA_W, 8, CCC config data width
COMMIT_ADDR, 6'h3F, write to this address starts relock wait
BUSY_TIMEOUT, 64, max ACCESS cycles with BUSY high before error
LOCK_TIMEOUT, 4096, max cycles waiting for stable LOCK after commit
LOCK_STABLE, 4, consecutive synchronized LOCK-high cycles required
PLL_RST_CYCLES, 16, PLL_ARST_N low width (optional feature only)

Ports:
PCLK  in  1  clock
PRESET_N  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  register address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  qualified by rsp_valid; 1 = BUSY or LOCK timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data from CCC
BUSY  in  1  CCC wait-state, active high
LOCK  in  1  CCC PLL lock, asynchronous
PLL_ARST_N  out  1  PLL reset to CCC, active low
relocking  out  1  high in LOCK_WAIT/PLL_RST

Behaviour:
- Reset values (PRESET_N=0 sampled on PCLK): state=IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, PLL_ARST_N=1, relocking=0, all counters 0.
- Reset asserted mid-transfer aborts immediately; no response is issued.
- States: IDLE, SETUP, ACCESS, PLL_RST, LOCK_WAIT, RESP.
- IDLE:
  - cmd_valid&cmd_ready captures write, addr and wdata into PADDR/PWRITE/PWDATA → SETUP.
  - Commands offered outside IDLE are not accepted.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle → ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - BUSY=0 → transfer completes this cycle; reads capture PRDATA into rsp_rdata.
  - BUSY=1 → increment busy counter. When the counter reaches BUSY_TIMEOUT: drop PSEL/PENABLE, set rsp_err=1 → RESP.
- Exit from a completed ACCESS:
  - Completed write with PADDR==COMMIT_ADDR → PLL_RST if feature enabled, else LOCK_WAIT.
  - Any other completion → RESP.
  - PSEL/PENABLE are 0 in the following cycle.
- LOCK_WAIT:
  - LOCK passes through a 2-flop synchronizer.
  - Stable counter increments while sync LOCK=1 and clears to 0 when sync LOCK=0.
  - Stable counter reaching LOCK_STABLE → RESP with rsp_err=0.
  - Timeout counter reaching LOCK_TIMEOUT first → RESP with rsp_err=1.
  - If stable and timeout are reached in the same cycle, success wins.
- RESP: rsp_valid=1 for one cycle → IDLE; cmd_ready=1 from the next cycle.
- Latency from accept cycle N: zero-wait read/write gives rsp_valid at N+3. Each BUSY cycle adds 1.
- Counters saturate and never wrap. Counter widths are $clog2(param)+1.
- Back-to-back: a new command can be accepted the cycle after rsp_valid.

Optional Feature:
- Macro: CCC_RECONFIG_PLL_RST_EN.
- Defined: a commit write enters PLL_RST, driving PLL_ARST_N=0 for PLL_RST_CYCLES cycles, then PLL_ARST_N=1 → LOCK_WAIT. The LOCK synchronizer history is cleared on entering LOCK_WAIT.
- Undefined: PLL_RST state is absent, PLL_ARST_N is constant 1, and a commit write goes directly to LOCK_WAIT.

Decomposition:
- Package ccc_reconfig_pkg: state enum, ADDR_W/DATA_W constants, COMMIT_ADDR default.
- One sub-module, ccc_lock_monitor: synchronizer, stable counter and timeout counter. Outputs lock_ok and lock_timeout pulses; input start clears it.

Test Plan:
- Read addr 6'h05, BUSY=0, PRDATA=8'hA7 → PSEL at N+1, PENABLE at N+2, rsp_valid at N+3 with rsp_rdata=8'hA7, rsp_err=0.
- Write addr 6'h10 data 8'h3C, BUSY high 5 cycles → PWDATA=8'h3C held stable throughout, rsp_valid at N+8, rsp_err=0.
- BUSY held high → after 64 ACCESS cycles PSEL drops, rsp_valid with rsp_err=1, cmd_ready back to 1.
- Write COMMIT_ADDR, LOCK rises 100 cycles later → relocking=1 throughout, rsp_valid within 100+2 sync+4 stable cycles, rsp_err=0. With the macro, PLL_ARST_N is low for exactly 16 cycles first.
- Commit with LOCK glitching 1,1,1,0 then stable → stable count restarts and completion needs 4 consecutive highs. With LOCK held 0 → rsp_err=1 at 4096 cycles.
- PRESET_N=0 during ACCESS → next cycle PSEL=PENABLE=0, no rsp_valid, cmd_ready=1 after release.
